wb_trace_buffer: RTL and testbench

WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

---
 rtl/wb_trace_buffer_pkg.sv | 21 ++
 rtl/wb_trace_buffer_fifo_mem.sv | 58 +++++
 rtl/wb_trace_buffer.sv | 143 ++++++++++++++
 tb/tb_wb_trace_buffer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_buffer_pkg.sv
// Shared types for the write-back trace buffer: the stored trace entry and the capture FSM state.
package wb_trace_buffer_pkg;

   // Entry fields are sized for the widest supported configuration; narrower builds zero-pad.
   localparam int MAX_XLEN  = 64;
   localparam int MAX_CYC_W = 64;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } trace_state_t;

   typedef struct packed {
      logic [MAX_XLEN-1:0]  pc;
      logic [MAX_XLEN-1:0]  instr;
      logic [MAX_XLEN-1:0]  data;
      logic [4:0]           rd;
      logic [MAX_CYC_W-1:0] cycle;
   } trace_entry_t;

endpackage

// File: rtl/wb_trace_buffer_fifo_mem.sv
// Entry storage and read/write pointers for the trace buffer; show-ahead head output, zero when empty.
import wb_trace_buffer_pkg::*;

module trace_fifo_mem #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  trace_entry_t             wr_entry,
   output trace_entry_t             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   trace_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Storage carries no reset; validity is tracked solely by count.
   always_ff @(posedge clk) begin
      if (push && !clear)
         mem[wr_ptr] <= wr_entry;
   end

   // Pointers are AW bits wide, so DEPTH being a power of two makes wrap-around free.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (!push && pop)
            count <= count - 1'b1;
      end
   end

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);
   assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back stage trace buffer: captures retiring register writes into a FIFO with drop accounting.
// Optional macro WB_TRACE_CYCLE_STAMP_EN adds a free-running cycle counter stamped into every entry.
import wb_trace_buffer_pkg::*;

module wb_trace_buffer #(
   parameter int XLEN         = 32,
   parameter int DEPTH        = 8,
   parameter int CYC_W        = 32,
   parameter int SKIP_X0      = 1,
   parameter int STOP_ON_FULL = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   trace_en,
   input  logic                   flush,
   input  logic [XLEN-1:0]        wb_pc,
   input  logic [XLEN-1:0]        wb_instruction,
   input  logic [XLEN-1:0]        wb_write_data,
   input  logic [4:0]             wb_rd_addr,
   input  logic                   wb_RegWrite,
   output logic                   tr_valid,
   input  logic                   tr_ready,
   output logic [XLEN-1:0]        tr_pc,
   output logic [XLEN-1:0]        tr_instr,
   output logic [XLEN-1:0]        tr_data,
   output logic [4:0]             tr_rd,
   output logic [CYC_W-1:0]       tr_cycle,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   output logic [15:0]            drop_cnt,
   output logic                   halted
);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   trace_state_t state;
   trace_state_t next_state;
   trace_entry_t wr_entry;
   trace_entry_t head;
   logic         capture;
   logic         pop;
   logic         push;
   logic         drop;
   logic         unused_head_bits;

   assign capture = trace_en && wb_RegWrite
                    && !((SKIP_X0 != 0) && (wb_rd_addr == 5'd0))
                    && (state == RUN);

   // Flush outranks both capture and pop; a pop frees the slot a full-buffer capture needs.
   assign tr_valid = !empty;
   assign pop      = tr_valid && tr_ready && !flush;
   assign push     = capture && (!full || pop) && !flush;
   assign drop     = capture && full && !pop && !flush;

`ifdef WB_TRACE_CYCLE_STAMP_EN
   logic [CYC_W-1:0] cycle_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cycle_cnt <= '0;
      else
         cycle_cnt <= cycle_cnt + 1'b1;
   end

   always_comb begin
      wr_entry                    = '0;
      wr_entry.pc[XLEN-1:0]       = wb_pc;
      wr_entry.instr[XLEN-1:0]    = wb_instruction;
      wr_entry.data[XLEN-1:0]     = wb_write_data;
      wr_entry.rd                 = wb_rd_addr;
      wr_entry.cycle[CYC_W-1:0]   = cycle_cnt;
   end

   assign tr_cycle = head.cycle[CYC_W-1:0];
`else
   always_comb begin
      wr_entry                    = '0;
      wr_entry.pc[XLEN-1:0]       = wb_pc;
      wr_entry.instr[XLEN-1:0]    = wb_instruction;
      wr_entry.data[XLEN-1:0]     = wb_write_data;
      wr_entry.rd                 = wb_rd_addr;
   end

   assign tr_cycle = '0;
`endif

   trace_fifo_mem #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .clear    (flush),
      .push     (push),
      .pop      (pop),
      .wr_entry (wr_entry),
      .head     (head),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   assign tr_pc    = head.pc[XLEN-1:0];
   assign tr_instr = head.instr[XLEN-1:0];
   assign tr_data  = head.data[XLEN-1:0];
   assign tr_rd    = head.rd;

   // Padding bits of the wide entry type are intentionally ignored.
   assign unused_head_bits = ^{head.pc, head.instr, head.data, head.cycle};

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         drop_cnt <= '0;
      else if (flush)
         drop_cnt <= '0;
      else if (drop)
         drop_cnt <= sat_inc16(drop_cnt);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= RUN;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         RUN:     if (drop && (STOP_ON_FULL != 0)) next_state = HALT;
         HALT:    if (flush) next_state = RUN;
         default: next_state = RUN;
      endcase
   end

   always_comb begin
      halted = (state == HALT);
   end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: a DEPTH=4 free-running instance and a DEPTH=4 stop-on-full instance.
module tb_wb_trace_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        trace_en;
   logic        flush;
   logic [31:0] wb_pc;
   logic [31:0] wb_instruction;
   logic [31:0] wb_write_data;
   logic [4:0]  wb_rd_addr;
   logic        wb_RegWrite;
   logic        tr_ready;

   logic        d_valid, h_valid;
   logic [31:0] d_pc, d_instr, d_data, h_pc, h_instr, h_data;
   logic [4:0]  d_rd, h_rd;
   logic [31:0] d_cycle, h_cycle;
   logic [2:0]  d_count, h_count;
   logic        d_full, d_empty, h_full, h_empty;
   logic [15:0] d_drop, h_drop;
   logic        d_halted, h_halted;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   wb_trace_buffer #(.XLEN(32), .DEPTH(4), .CYC_W(32), .SKIP_X0(1), .STOP_ON_FULL(0)) dut (
      .clk(clk), .reset(reset), .trace_en(trace_en), .flush(flush),
      .wb_pc(wb_pc), .wb_instruction(wb_instruction), .wb_write_data(wb_write_data),
      .wb_rd_addr(wb_rd_addr), .wb_RegWrite(wb_RegWrite),
      .tr_valid(d_valid), .tr_ready(tr_ready), .tr_pc(d_pc), .tr_instr(d_instr),
      .tr_data(d_data), .tr_rd(d_rd), .tr_cycle(d_cycle), .count(d_count),
      .full(d_full), .empty(d_empty), .drop_cnt(d_drop), .halted(d_halted));

   wb_trace_buffer #(.XLEN(32), .DEPTH(4), .CYC_W(32), .SKIP_X0(1), .STOP_ON_FULL(1)) dut_h (
      .clk(clk), .reset(reset), .trace_en(trace_en), .flush(flush),
      .wb_pc(wb_pc), .wb_instruction(wb_instruction), .wb_write_data(wb_write_data),
      .wb_rd_addr(wb_rd_addr), .wb_RegWrite(wb_RegWrite),
      .tr_valid(h_valid), .tr_ready(tr_ready), .tr_pc(h_pc), .tr_instr(h_instr),
      .tr_data(h_data), .tr_rd(h_rd), .tr_cycle(h_cycle), .count(h_count),
      .full(h_full), .empty(h_empty), .drop_cnt(h_drop), .halted(h_halted));

   typedef struct {
      logic        en;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] data;
      logic        rdy;
      logic [2:0]  ecount;
      logic        evalid;
      logic [31:0] epc;
      logic [31:0] edata;
      logic [15:0] edrop;
   } vec_t;

   vec_t tbl [17];

   function automatic vec_t mk(logic en, logic we, logic [4:0] rd, logic [31:0] pc, logic [31:0] data,
                               logic rdy, logic [2:0] ec, logic ev, logic [31:0] epc,
                               logic [31:0] edata, logic [15:0] edrop);
      vec_t v;
      v.en = en; v.we = we; v.rd = rd; v.pc = pc; v.data = data; v.rdy = rdy;
      v.ecount = ec; v.evalid = ev; v.epc = epc; v.edata = edata; v.edrop = edrop;
      return v;
   endfunction

   function automatic logic [31:0] instr_of(logic [31:0] pc);
      return pc ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] pc,
                        input logic [31:0] data, input logic rdy);
      wb_RegWrite    = we;
      wb_rd_addr     = rd;
      wb_pc          = pc;
      wb_instruction = instr_of(pc);
      wb_write_data  = data;
      tr_ready       = rdy;
   endtask

   initial begin
      int elapsed;
      logic [31:0] exp_stamp;

      reset = 1'b1; trace_en = 1'b0; flush = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);

      // Reset state of both instances.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 64'(d_count), 64'd0);
      chk("rst_empty", 64'(d_empty), 64'd1);
      chk("rst_full", 64'(d_full), 64'd0);
      chk("rst_valid", 64'(d_valid), 64'd0);
      chk("rst_drop", 64'(d_drop), 64'd0);
      chk("rst_halted", 64'(d_halted), 64'd0);
      chk("rst_trfields", 64'({d_pc, d_instr} | 64'(d_data) | 64'(d_rd) | 64'(d_cycle)), 64'd0);
      chk("rst_h_status", 64'({h_count, h_full, h_empty, h_valid, h_drop, h_halted}), 64'(8'b000_0_1_0 << 17));
      chk("rst_h_trfields", 64'({h_pc, h_instr} | 64'(h_data) | 64'(h_rd) | 64'(h_cycle)), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      trace_en = 1'b1;

      //            en    we    rd     pc      data    rdy   cnt  vld   epc     edata   edrop
      tbl[0]  = mk(1'b1, 1'b1, 5'd1,  32'd0,  32'd5,  1'b1, 3'd1, 1'b1, 32'd0,  32'd5,   16'd0);
      tbl[1]  = mk(1'b1, 1'b1, 5'd2,  32'd4,  32'd7,  1'b1, 3'd1, 1'b1, 32'd4,  32'd7,   16'd0);
      tbl[2]  = mk(1'b1, 1'b1, 5'd3,  32'd8,  32'd12, 1'b1, 3'd1, 1'b1, 32'd8,  32'd12,  16'd0);
      tbl[3]  = mk(1'b1, 1'b0, 5'd0,  32'd0,  32'd0,  1'b1, 3'd0, 1'b0, 32'd0,  32'd0,   16'd0);
      tbl[4]  = mk(1'b1, 1'b1, 5'd0,  32'd12, 32'd9,  1'b0, 3'd0, 1'b0, 32'd0,  32'd0,   16'd0);
      tbl[5]  = mk(1'b0, 1'b1, 5'd6,  32'd12, 32'd9,  1'b0, 3'd0, 1'b0, 32'd0,  32'd0,   16'd0);
      tbl[6]  = mk(1'b1, 1'b1, 5'd4,  32'd16, 32'd100, 1'b0, 3'd1, 1'b1, 32'd16, 32'd100, 16'd0);
      tbl[7]  = mk(1'b1, 1'b1, 5'd5,  32'd20, 32'd101, 1'b0, 3'd2, 1'b1, 32'd16, 32'd100, 16'd0);
      tbl[8]  = mk(1'b1, 1'b1, 5'd6,  32'd24, 32'd102, 1'b0, 3'd3, 1'b1, 32'd16, 32'd100, 16'd0);
      tbl[9]  = mk(1'b1, 1'b1, 5'd7,  32'd28, 32'd103, 1'b0, 3'd4, 1'b1, 32'd16, 32'd100, 16'd0);
      tbl[10] = mk(1'b1, 1'b1, 5'd8,  32'd32, 32'd104, 1'b0, 3'd4, 1'b1, 32'd16, 32'd100, 16'd1);
      tbl[11] = mk(1'b1, 1'b1, 5'd9,  32'd36, 32'd105, 1'b0, 3'd4, 1'b1, 32'd16, 32'd100, 16'd2);
      tbl[12] = mk(1'b1, 1'b1, 5'd10, 32'd40, 32'd106, 1'b1, 3'd4, 1'b1, 32'd20, 32'd101, 16'd2);
      tbl[13] = mk(1'b1, 1'b0, 5'd0,  32'd0,  32'd0,   1'b1, 3'd3, 1'b1, 32'd24, 32'd102, 16'd2);
      tbl[14] = mk(1'b1, 1'b0, 5'd0,  32'd0,  32'd0,   1'b1, 3'd2, 1'b1, 32'd28, 32'd103, 16'd2);
      tbl[15] = mk(1'b1, 1'b0, 5'd0,  32'd0,  32'd0,   1'b1, 3'd1, 1'b1, 32'd40, 32'd106, 16'd2);
      tbl[16] = mk(1'b1, 1'b0, 5'd0,  32'd0,  32'd0,   1'b1, 3'd0, 1'b0, 32'd0,  32'd0,   16'd2);

      for (int i = 0; i < 17; i++) begin
         trace_en = tbl[i].en;
         drive(tbl[i].we, tbl[i].rd, tbl[i].pc, tbl[i].data, tbl[i].rdy);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_count", i), 64'(d_count), 64'(tbl[i].ecount));
         chk($sformatf("v%0d_valid", i), 64'(d_valid), 64'(tbl[i].evalid));
         chk($sformatf("v%0d_full", i), 64'(d_full), 64'(tbl[i].ecount == 3'd4));
         chk($sformatf("v%0d_empty", i), 64'(d_empty), 64'(tbl[i].ecount == 3'd0));
         chk($sformatf("v%0d_drop", i), 64'(d_drop), 64'(tbl[i].edrop));
         if (tbl[i].evalid) begin
            chk($sformatf("v%0d_pc", i), 64'(d_pc), 64'(tbl[i].epc));
            chk($sformatf("v%0d_data", i), 64'(d_data), 64'(tbl[i].edata));
            chk($sformatf("v%0d_instr", i), 64'(d_instr), 64'(instr_of(tbl[i].epc)));
         end
      end

      // Flush with a simultaneous capture: flush wins, halt state cleared.
      trace_en = 1'b1;
      flush = 1'b1;
      drive(1'b1, 5'd1, 32'h50, 32'h1, 1'b0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("fl0_d_empty", 64'(d_empty), 64'd1);
      chk("fl0_h_empty", 64'(h_empty), 64'd1);
      chk("fl0_h_halted", 64'(h_halted), 64'd0);
      chk("fl0_h_drop", 64'(h_drop), 64'd0);

      // Overflow against the stop-on-full instance.
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 5'(i + 1), 32'd100 + 32'(4 * i), 32'(i), 1'b0);
         @(posedge clk);
         #1;
         if (i == 4) begin
            chk("sof_halt_on_drop", 64'(h_halted), 64'd1);
            chk("sof_first_drop", 64'(h_drop), 64'd1);
         end
      end
      chk("sof_h_halted", 64'(h_halted), 64'd1);
      chk("sof_h_drop_frozen", 64'(h_drop), 64'd1);
      chk("sof_h_count", 64'(h_count), 64'd4);
      chk("sof_h_head", 64'(h_pc), 64'd100);
      chk("sof_d_drop", 64'(d_drop), 64'd3);
      chk("sof_d_halted", 64'(d_halted), 64'd0);

      drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("sof_fl_empty", 64'(h_empty), 64'd1);
      chk("sof_fl_halted", 64'(h_halted), 64'd0);
      chk("sof_fl_drop", 64'(h_drop), 64'd0);
      chk("sof_fl_d_drop", 64'(d_drop), 64'd0);

      drive(1'b1, 5'd2, 32'h200, 32'h22, 1'b0);
      @(posedge clk);
      #1;
      chk("sof_rerun_count", 64'(h_count), 64'd1);
      chk("sof_rerun_pc", 64'(h_pc), 64'h200);

      // Reach count=3, then assert reset between edges.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 5'd3, 32'h300 + 32'(4 * i), 32'h33, 1'b0);
         @(posedge clk);
         #1;
      end
      chk("ar_pre_count", 64'(d_count), 64'd3);
      drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_count", 64'(d_count), 64'd0);
      chk("ar_valid", 64'(d_valid), 64'd0);
      chk("ar_pc", 64'(d_pc), 64'd0);
      chk("ar_h_count", 64'(h_count), 64'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Cycle stamp of the first capture after reset release.
      elapsed = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         elapsed++;
      end
      #1;
      drive(1'b1, 5'd5, 32'h400, 32'h44, 1'b0);
      @(posedge clk);
      #1;
      drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
`ifdef WB_TRACE_CYCLE_STAMP_EN
      exp_stamp = 32'(elapsed);
`else
      exp_stamp = 32'd0;
`endif
      chk("cs_count", 64'(d_count), 64'd1);
      chk("cs_pc", 64'(d_pc), 64'h400);
      chk("cs_rd", 64'(d_rd), 64'd5);
      chk("cs_stamp", 64'(d_cycle), 64'(exp_stamp));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
